// File: rtl/spi_rdid_monitor.sv
// Passive SPI monitor: decodes chip-select frames, captures the opcode and the RDID response.
// Optional build macro SPI_MON_SYNC_EN adds a 2-flop synchroniser for a bus asynchronous to clk.
module spi_rdid_monitor #(
  parameter logic [7:0]  RDID_OPCODE = 8'h9F,
  parameter logic [23:0] EXPECTED_ID = 24'h202015
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SPICLK,
  input  logic        SPIMOSI,
  input  logic        SPIMISO,
  input  logic        chip_select,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  output logic [23:0] id,
  output logic        id_valid,
  output logic        id_match,
  output logic        frame_error,
  output logic [7:0]  match_count
);

  typedef enum logic [1:0] {IDLE, CMD, RESP, IGNORE} state_t;

  // Bus bundle ordering: {sclk, mosi, miso, cs_n}
  logic [3:0] bus_raw;

`ifdef SPI_MON_SYNC_EN
  logic [3:0] sync_1, sync_2;

  always_ff @(posedge clk) begin
    sync_1 <= {SPICLK, SPIMOSI, SPIMISO, chip_select};
    sync_2 <= sync_1;
  end

  assign bus_raw = sync_2;
`else
  assign bus_raw = {SPICLK, SPIMOSI, SPIMISO, chip_select};
`endif

  logic sclk_q, mosi_q, miso_q, cs_q;
  logic sclk_d, cs_d;

  // NOTE: the bus pipeline is deliberately not reset, so that cs_d reflects the real
  // chip_select level as reset releases and a frame already in progress is ignored.
  always_ff @(posedge clk) begin
    {sclk_q, mosi_q, miso_q, cs_q} <= bus_raw;
    sclk_d <= sclk_q;
    cs_d   <= cs_q;
  end

  logic        sclk_rise;
  logic [7:0]  cmd_next;
  logic [23:0] id_next;
  logic [22:0] shift;
  logic [4:0]  bit_cnt;
  state_t      state;

  assign sclk_rise = sclk_q & ~sclk_d;
  assign cmd_next  = {shift[6:0], mosi_q};
  assign id_next   = {shift, miso_q};

  // NOTE: every register here uses non-blocking assignment so all updates in one
  // clock cycle see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      cmd         <= '0;
      cmd_valid   <= 1'b0;
      id          <= '0;
      id_valid    <= 1'b0;
      id_match    <= 1'b0;
      frame_error <= 1'b0;
      match_count <= '0;
    end else begin
      cmd_valid   <= 1'b0;
      id_valid    <= 1'b0;
      frame_error <= 1'b0;

      case (state)
        IDLE: begin
          // Only a genuine falling transition starts a frame; a low level seen
          // without one means we joined mid-frame.
          if (!cs_q) begin
            bit_cnt <= '0;
            state   <= cs_d ? CMD : IGNORE;
          end
        end

        CMD: begin
          if (cs_q) begin
            if (bit_cnt != 5'd0) frame_error <= 1'b1;
            state <= IDLE;
          end else if (sclk_rise) begin
            shift <= {shift[21:0], mosi_q};
            if (bit_cnt == 5'd7) begin
              cmd       <= cmd_next;
              cmd_valid <= 1'b1;
              bit_cnt   <= '0;
              state     <= (cmd_next == RDID_OPCODE) ? RESP : IGNORE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end

        RESP: begin
          if (cs_q) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end else if (sclk_rise) begin
            shift <= id_next[22:0];
            if (bit_cnt == 5'd23) begin
              id       <= id_next;
              id_valid <= 1'b1;
              id_match <= (id_next == EXPECTED_ID);
              if (id_next == EXPECTED_ID && match_count != 8'hFF)
                match_count <= match_count + 8'd1;
              bit_cnt <= '0;
              state   <= IGNORE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end

        IGNORE: begin
          if (cs_q) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_rdid_monitor.md
# spi_rdid_monitor

Passive SPI bus monitor on the link between `spi_master` and the M25P16 serial flash. It decodes each chip-select frame, captures the opcode driven on SPIMOSI and, for the RDID opcode (0x9F), the 24-bit identification returned on SPIMISO. It then compares that ID against an expected value and reports the result. The block drives nothing on the SPI bus and is used in-system as a bring-up and health indicator.

## Interface
- `RDID_OPCODE`, 8'h9F, opcode that triggers ID capture
- `EXPECTED_ID`, 24'h202015, expected {manufacturer, memory type, capacity}

- `clk` input 1: system clock; SPICLK is derived from it (SPICLK ≤ clk/2)
- `reset` input 1: synchronous, active-high
- `SPICLK` input 1: bus clock, mode 0 (idle low, sample on rising edge)
- `SPIMOSI` input 1: master-to-flash data, MSB first
- `SPIMISO` input 1: flash-to-master data, MSB first
- `chip_select` input 1: active-low frame enable
- `cmd` output 8: last captured opcode, held
- `cmd_valid` output 1: one-cycle pulse when `cmd` updates
- `id` output 24: last captured RDID response, held
- `id_valid` output 1: one-cycle pulse when `id` updates
- `id_match` output 1: `id == EXPECTED_ID`; updated together with `id_valid`, held
- `frame_error` output 1: one-cycle pulse on an aborted frame
- `match_count` output 8: count of matching RDID frames, saturates at 255

## Operation
- Reset values: all outputs 0. The FSM enters IDLE and the bit counter clears.
- Bus inputs are registered before use. A rising SPICLK edge is detected as registered SPICLK = 1 while the previous registered value = 0. MOSI and MISO are sampled from the same register stage on that cycle.
- **IDLE:** Wait for `chip_select` = 0, then go to CMD with bit counter = 0.
- **CMD:** On each rising edge, shift in MOSI.
  - After the 8th bit, load `cmd` and pulse `cmd_valid`.
  - If the opcode equals `RDID_OPCODE`, go to RESP with counter = 0. Otherwise go to IGNORE.
- **RESP:** On each rising edge, shift in MISO.
  - After the 24th bit, load `id`, pulse `id_valid`, and update `id_match`.
  - On a match, increment `match_count`, saturating.
  - Then go to IGNORE.
- **IGNORE:** Discard all further edges until `chip_select` = 1, then return to IDLE.
- **Abort:** `chip_select` = 1 seen in CMD with 1–7 bits, or in RESP with 0–23 bits, pulses `frame_error` and returns to IDLE.
  - `cmd`, `id` and `id_match` are not modified.
  - A frame that ends in CMD with 0 bits is not an error.
- **Simultaneous events:** `chip_select` rising and an SPICLK edge in the same cycle: deselect wins and the edge is ignored.
- **Mid-frame reset:** All outputs clear. The monitor resynchronises at the next `chip_select` falling transition. If `chip_select` is already low when reset releases, the FSM goes to IGNORE, not CMD.

## Timing
- `cmd_valid` and `id_valid` assert exactly 2 clk cycles after the SPICLK rising edge that carries the last bit of the field, measured at the pins.
- `frame_error` asserts 2 clk cycles after `chip_select` rises at the pins.
- `id_match` and `match_count` change in the same cycle that `id_valid` is high.
- Minimum SPICLK high and low time: 1 clk cycle. Minimum `chip_select` high time between frames: 1 clk cycle.
- With `SPI_MON_SYNC_EN` defined, every latency above increases by 2 cycles.

## Configuration
- Macro: `SPI_MON_SYNC_EN`.
- **Defined:** A 2-flop synchroniser is inserted on SPICLK, SPIMOSI, SPIMISO and `chip_select`, ahead of the edge-detect register. Use this when the bus is asynchronous to `clk`; SPICLK must then be ≤ clk/4.
- **Undefined:** A single input register, which is valid only when the bus is generated from `clk`.
- Functional behaviour is identical in both builds apart from latency.

## Test plan
- **RDID match:** `spi_master` with the flash model, `get_rdid` pulse → `cmd_valid` with `cmd` = 0x9F, then `id_valid` with `id` = 0x202015, `id_match` = 1, `match_count` = 1.
- **ID mismatch:** Bus model returns 0x202016 → `id_valid`, `id` = 0x202016, `id_match` = 0, `match_count` unchanged.
- **Non-RDID opcode:** Frame with opcode 0x05 and 16 further clocks → `cmd` = 0x05, no `id_valid`, no `frame_error`.
- **Aborted frame:** Opcode 0x9F, then `chip_select` raised after 12 MISO bits → `frame_error` pulse 2 cycles later, `id`/`id_match` unchanged, next full frame captured correctly.
- **Mid-frame reset and saturation:**
  - Reset asserted during bit 5 of RESP → all outputs 0. With `chip_select` still low, no capture occurs; the next frame yields 0x202015.
  - 256 matching frames → `match_count` holds at 255.
- **Sync build:** Repeat the RDID match scenario with `SPI_MON_SYNC_EN` defined → same values, `cmd_valid` 4 cycles after the 8th SPICLK rising edge.
